// File: rtl/spi_bus_arbiter.sv
// Two-master arbiter for the shared SPI flash/RAM bus: req/gnt handshake, whole-tenure
// ownership, and a forced deselect gap between tenures so the flash sees its tSHSL.
module spi_bus_arbiter #(
  parameter int GAP_CYCLES = 2,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic cpu_clk,
  input  logic rstn,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  input  logic m0_sel_n,
  input  logic m1_sel_n,
  input  logic m0_mosi,
  input  logic m1_mosi,
  input  logic m0_clk_en,
  input  logic m1_clk_en,
  output logic m0_miso,
  output logic m1_miso,
  output logic spi_select_n,
  output logic spi_mosi,
  output logic spi_clk_enable,
  input  logic spi_miso,
  output logic err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_gap_cnt;
  logic [3:0] w_gap_cnt_nxt;
  logic       r_last_owner;
  logic       w_last_owner_nxt;
  logic       r_err;
  logic       w_err_nxt;

  // last_owner resets to 1 so master 0 takes the first round-robin tie
  always_ff @(posedge cpu_clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_gap_cnt    <= 4'd0;
      r_last_owner <= 1'b1;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_err        <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_last_owner_nxt = r_last_owner;
    w_err_nxt        = r_err;
    spi_select_n     = 1'b1;
    spi_mosi         = 1'b0;
    spi_clk_enable   = 1'b0;
    m0_miso          = 1'b0;
    m1_miso          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (req0 && req1) begin
          w_state_nxt = (FIXED_PRIO || r_last_owner) ? S_OWN0 : S_OWN1;
        end else if (req0) begin
          w_state_nxt = S_OWN0;
        end else if (req1) begin
          w_state_nxt = S_OWN1;
        end
      end

      // Bus follows the owner combinationally so select-low costs no extra cycle
      S_OWN0: begin
        spi_select_n   = m0_sel_n;
        spi_mosi       = m0_mosi;
        spi_clk_enable = m0_clk_en;
        m0_miso        = spi_miso;
        if (!req0) begin
          w_last_owner_nxt = 1'b0;
          w_err_nxt        = r_err | ~m0_sel_n;
          w_state_nxt      = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          w_gap_cnt_nxt    = GAP_LOAD;
        end
      end

      S_OWN1: begin
        spi_select_n   = m1_sel_n;
        spi_mosi       = m1_mosi;
        spi_clk_enable = m1_clk_en;
        m1_miso        = spi_miso;
        if (!req1) begin
          w_last_owner_nxt = 1'b1;
          w_err_nxt        = r_err | ~m1_sel_n;
          w_state_nxt      = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          w_gap_cnt_nxt    = GAP_LOAD;
        end
      end

      S_GAP: begin
        if (r_gap_cnt == 4'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 4'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign gnt0 = (r_state == S_OWN0);
  assign gnt1 = (r_state == S_OWN1);
  assign err  = r_err;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Randomized scoreboard bench for spi_bus_arbiter: three builds (round-robin, fixed
// priority, zero gap) driven by master agents and checked against a deadline model.
module tb_spi_bus_arbiter;

  localparam int NDUT = 3;
  localparam int GAP_P [NDUT] = '{2, 2, 0};
  localparam bit FIX_P [NDUT] = '{1'b0, 1'b1, 1'b0};

  logic cpu_clk = 1'b0;
  logic rstn;
  logic spi_miso;
  logic [1:0] req   [NDUT];
  logic [1:0] sel_n [NDUT];
  logic [1:0] mosi  [NDUT];
  logic [1:0] clken [NDUT];
  logic [NDUT-1:0] gnt0_o, gnt1_o, sel_o, mosi_o, clken_o, miso0_o, miso1_o, err_o;

  int checks   = 0;
  int failures = 0;
  bit agents_on = 1'b0;
  int busy_n    = 0;
  int max_idle  = 6;

  always #5 cpu_clk = ~cpu_clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    spi_bus_arbiter #(
      .GAP_CYCLES(GAP_P[g]),
      .FIXED_PRIO(FIX_P[g])
    ) u_dut (
      .cpu_clk       (cpu_clk),
      .rstn          (rstn),
      .req0          (req[g][0]),
      .req1          (req[g][1]),
      .gnt0          (gnt0_o[g]),
      .gnt1          (gnt1_o[g]),
      .m0_sel_n      (sel_n[g][0]),
      .m1_sel_n      (sel_n[g][1]),
      .m0_mosi       (mosi[g][0]),
      .m1_mosi       (mosi[g][1]),
      .m0_clk_en     (clken[g][0]),
      .m1_clk_en     (clken[g][1]),
      .m0_miso       (miso0_o[g]),
      .m1_miso       (miso1_o[g]),
      .spi_select_n  (sel_o[g]),
      .spi_mosi      (mosi_o[g]),
      .spi_clk_enable(clken_o[g]),
      .spi_miso      (spi_miso),
      .err           (err_o[g])
    );
  end

  task automatic chk(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  function automatic logic gnt_of(input int d, input int m);
    return (m == 0) ? gnt0_o[d] : gnt1_o[d];
  endfunction

  // Reference model: ownership plus the earliest edge at which a new decision may be taken.
  // own encoding in the queue: 0 = nobody, 1 = master 0, 2 = master 1.
  typedef struct packed {
    logic [NDUT-1:0][1:0] own;
    logic [NDUT-1:0]      err;
  } exp_t;

  exp_t exp_q[$];
  int   m_owner [NDUT];
  int   m_free  [NDUT];
  int   m_last  [NDUT];
  bit   m_err   [NDUT];
  int   edge_n = 0;

  initial forever begin
    exp_t e;
    @(posedge cpu_clk);
    edge_n++;
    for (int d = 0; d < NDUT; d++) begin
      if (!rstn) begin
        m_owner[d] = -1;
        m_free[d]  = edge_n + 1;
        m_last[d]  = 1;
        m_err[d]   = 1'b0;
      end else if (m_owner[d] >= 0) begin
        if (!req[d][m_owner[d]]) begin
          if (!sel_n[d][m_owner[d]]) m_err[d] = 1'b1;
          m_last[d]  = m_owner[d];
          m_owner[d] = -1;
          m_free[d]  = edge_n + GAP_P[d] + 1;
        end
      end else if (edge_n >= m_free[d]) begin
        if (req[d] == 2'b11) m_owner[d] = FIX_P[d] ? 0 : 1 - m_last[d];
        else if (req[d][0])  m_owner[d] = 0;
        else if (req[d][1])  m_owner[d] = 1;
      end
      e.own[d] = 2'(m_owner[d] + 1);
      e.err[d] = m_err[d];
    end
    exp_q.push_back(e);
  end

  // Monitor: one expected record per edge, compared mid-cycle against grants, err and the bus mux
  int run_hi  [NDUT];
  bit seen_lo [NDUT];

  initial forever begin
    exp_t       e;
    logic [1:0] o;
    logic [4:0] bus_exp;
    @(negedge cpu_clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int d = 0; d < NDUT; d++) begin
        o = e.own[d];
        chk("grant", d, 8'({gnt1_o[d], gnt0_o[d]}), 8'({o == 2'd2, o == 2'd1}));
        chk("err", d, 8'(err_o[d]), 8'(e.err[d]));
        case (o)
          2'd1:    bus_exp = {sel_n[d][0], mosi[d][0], clken[d][0], spi_miso, 1'b0};
          2'd2:    bus_exp = {sel_n[d][1], mosi[d][1], clken[d][1], 1'b0, spi_miso};
          default: bus_exp = 5'b10000;
        endcase
        chk("bus", d, 8'({sel_o[d], mosi_o[d], clken_o[d], miso0_o[d], miso1_o[d]}), 8'(bus_exp));
        if (!rstn) begin
          seen_lo[d] = 1'b0;
          run_hi[d]  = 0;
        end else if (sel_o[d]) begin
          run_hi[d]++;
        end else begin
          if (seen_lo[d] && run_hi[d] > 0)
            chk("sel_gap", d, 8'((run_hi[d] > GAP_P[d]) ? GAP_P[d] + 1 : run_hi[d]), 8'(GAP_P[d] + 1));
          seen_lo[d] = 1'b1;
          run_hi[d]  = 0;
        end
      end
    end
  end

  initial forever begin
    @(posedge cpu_clk);
    #1;
    spi_miso = 1'($urandom);
  end

  // Master agent: request, wait for grant, run a random transfer, deselect, release
  task automatic agent(input int d, input int m);
    int waited;
    busy_n++;
    while (agents_on) begin
      req[d][m] = 1'b1;
      waited = 0;
      while (!gnt_of(d, m) && waited < 100) begin
        sel_n[d][m] = ($urandom_range(0, 7) != 0);
        @(posedge cpu_clk); #1;
        waited++;
      end
      if (!(FIX_P[d] && m == 1)) chk("grant_wait", d, 8'(gnt_of(d, m)), 8'd1);
      if (gnt_of(d, m)) begin
        repeat ($urandom_range(1, 10)) begin
          sel_n[d][m] = 1'b0;
          mosi[d][m]  = 1'($urandom);
          clken[d][m] = 1'($urandom);
          @(posedge cpu_clk); #1;
        end
        sel_n[d][m] = 1'b1;
        mosi[d][m]  = 1'b0;
        clken[d][m] = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge cpu_clk); #1;
        end
      end else begin
        sel_n[d][m] = 1'b1;
      end
      req[d][m] = 1'b0;
      @(posedge cpu_clk); #1;
      repeat ($urandom_range(0, max_idle)) begin
        @(posedge cpu_clk); #1;
      end
    end
    busy_n--;
  endtask

  task automatic wait_all_gnt(input int m, input string name);
    int w;
    logic [NDUT-1:0] g;
    w = 0;
    g = (m == 0) ? gnt0_o : gnt1_o;
    while (g != '1 && w < 40) begin
      @(posedge cpu_clk); #1;
      w++;
      g = (m == 0) ? gnt0_o : gnt1_o;
    end
    chk(name, 0, 8'(g), 8'((1 << NDUT) - 1));
  endtask

  initial begin
    int w;
    rstn     = 1'b0;
    spi_miso = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      req[d]   = 2'b11;
      sel_n[d] = 2'b11;
      mosi[d]  = 2'b00;
      clken[d] = 2'b00;
    end
    repeat (3) @(posedge cpu_clk);
    #1;
    rstn      = 1'b1;
    agents_on = 1'b1;
    for (int i = 0; i < 2 * NDUT; i++) begin
      fork
        automatic int k = i;
        agent(k / 2, k % 2);
      join_none
    end
    @(posedge cpu_clk); #1;
    for (int d = 0; d < NDUT; d++)
      chk("first_grant", d, 8'({gnt1_o[d], gnt0_o[d]}), 8'b01);

    repeat (2000) @(posedge cpu_clk);
    #1;
    max_idle = 0;
    repeat (400) @(posedge cpu_clk);
    #1;
    agents_on = 1'b0;
    w = 0;
    while (busy_n != 0 && w < 500) begin
      @(posedge cpu_clk); #1;
      w++;
    end
    repeat (6) begin
      @(posedge cpu_clk); #1;
    end

    // Owner releases while its select is still low
    for (int d = 0; d < NDUT; d++) req[d][0] = 1'b1;
    wait_all_gnt(0, "err_phase_grant");
    for (int d = 0; d < NDUT; d++) sel_n[d][0] = 1'b0;
    repeat (2) begin
      @(posedge cpu_clk); #1;
    end
    for (int d = 0; d < NDUT; d++) req[d][0] = 1'b0;
    @(posedge cpu_clk); #1;
    for (int d = 0; d < NDUT; d++)
      chk("err_set", d, 8'({err_o[d], sel_o[d], gnt0_o[d]}), 8'b110);
    for (int d = 0; d < NDUT; d++) sel_n[d][0] = 1'b1;
    repeat (6) begin
      @(posedge cpu_clk); #1;
    end
    for (int d = 0; d < NDUT; d++)
      chk("err_sticky", d, 8'(err_o[d]), 8'd1);

    // Reset in the middle of a master-1 tenure
    for (int d = 0; d < NDUT; d++) req[d][1] = 1'b1;
    wait_all_gnt(1, "rst_phase_grant");
    for (int d = 0; d < NDUT; d++) sel_n[d][1] = 1'b0;
    @(posedge cpu_clk); #1;
    for (int d = 0; d < NDUT; d++)
      chk("owner_sel", d, 8'({sel_o[d], gnt1_o[d]}), 8'b01);
    rstn = 1'b0;
    @(posedge cpu_clk); #1;
    for (int d = 0; d < NDUT; d++)
      chk("reset_drop", d, 8'({sel_o[d], gnt1_o[d], err_o[d]}), 8'b100);
    rstn = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      req[d]   = 2'b01;
      sel_n[d] = 2'b11;
    end
    @(posedge cpu_clk); #1;
    for (int d = 0; d < NDUT; d++)
      chk("post_reset_grant", d, 8'({gnt1_o[d], gnt0_o[d]}), 8'b01);
    for (int d = 0; d < NDUT; d++) req[d] = 2'b00;
    repeat (4) @(posedge cpu_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
